// File: rtl/ysyx_24110006_read_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_24110006_pkg
// Shared definitions for the core's read-channel arbitration logic.
//   - arb_state_t / ST_* : read arbiter FSM encoding (IDLE, ADDR, DATA)
//   - mst_id_t / MST_*   : master identifiers (IFU is master 0, LSU is master 1)
// ---------------------------------------------------------------------------
package ysyx_24110006_pkg;

  typedef logic [1:0] arb_state_t;
  typedef logic       mst_id_t;

  localparam arb_state_t ST_IDLE = 2'd0;
  localparam arb_state_t ST_ADDR = 2'd1;
  localparam arb_state_t ST_DATA = 2'd2;

  localparam mst_id_t MST_IFU = 1'b0;
  localparam mst_id_t MST_LSU = 1'b1;

endpackage

// File: rtl/ysyx_24110006_read_arbiter_rr_grant2.sv
// ---------------------------------------------------------------------------
// ysyx_24110006_rr_grant2
// Two-requester round-robin grant, purely combinational.
//   req[1:0]   in  request vector (bit 0 = IFU, bit 1 = LSU)
//   last       in  ID of the master served most recently
//   grant[1:0] out one-hot grant, all zero when nobody requests
// On a tie the master that was NOT served last wins.
// ---------------------------------------------------------------------------
module ysyx_24110006_rr_grant2
  import ysyx_24110006_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  // One-hot grant selection with round-robin tie break
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11: begin
        if (last == MST_LSU) begin
          grant = 2'b01;
        end else begin
          grant = 2'b10;
        end
      end
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/ysyx_24110006_read_arbiter.sv
// ---------------------------------------------------------------------------
// ysyx_24110006_read_arbiter
// Shares the single downstream AXI4-Lite read port between the IFU (master 0)
// and the LSU (master 1). One read is outstanding at a time; contention is
// resolved round-robin. The winning address is registered and presented
// downstream; the response is routed back to the owning master only.
//
// Ports
//   i_clock, i_reset               clock, synchronous active-high reset
//   i_mX_araddr/arvalid, o_mX_arready   master read-address channels
//   o_mX_rdata/rresp/rvalid, i_mX_rready master read-data channels
//   o_s_araddr/arvalid, i_s_arready      downstream read-address channel
//   i_s_rdata/rresp/rvalid, o_s_rready   downstream read-data channel
//
// Sequence: IDLE (master handshake) -> ADDR (downstream AR) -> DATA (R beat).
// rdata/rresp are broadcast to both masters; only the owner sees rvalid, so
// error responses (SLVERR/DECERR) pass through untouched.
// ---------------------------------------------------------------------------
module ysyx_24110006_read_arbiter
  import ysyx_24110006_pkg::*;
(
  input  logic        i_clock,
  input  logic        i_reset,

  input  logic [31:0] i_m0_araddr,
  input  logic        i_m0_arvalid,
  output logic        o_m0_arready,
  output logic [31:0] o_m0_rdata,
  output logic [1:0]  o_m0_rresp,
  output logic        o_m0_rvalid,
  input  logic        i_m0_rready,

  input  logic [31:0] i_m1_araddr,
  input  logic        i_m1_arvalid,
  output logic        o_m1_arready,
  output logic [31:0] o_m1_rdata,
  output logic [1:0]  o_m1_rresp,
  output logic        o_m1_rvalid,
  input  logic        i_m1_rready,

  output logic [31:0] o_s_araddr,
  output logic        o_s_arvalid,
  input  logic        i_s_arready,
  input  logic [31:0] i_s_rdata,
  input  logic [1:0]  i_s_rresp,
  input  logic        i_s_rvalid,
  output logic        o_s_rready
);

  arb_state_t  state_r;
  mst_id_t     owner_r;
  mst_id_t     last_r;
  logic [31:0] addr_r;
  logic [1:0]  grant_s;

  ysyx_24110006_rr_grant2 u_rr_grant2 (
    .req   ({i_m1_arvalid, i_m0_arvalid}),
    .last  (last_r),
    .grant (grant_s)
  );

  // Read data/response are shared by both masters; rvalid selects the owner
  assign o_m0_rdata = i_s_rdata;
  assign o_m1_rdata = i_s_rdata;
  assign o_m0_rresp = i_s_rresp;
  assign o_m1_rresp = i_s_rresp;
  assign o_s_araddr = addr_r;

  // Handshake outputs decoded from the current state
  always_comb begin
    o_m0_arready = 1'b0;
    o_m1_arready = 1'b0;
    o_s_arvalid  = 1'b0;
    o_s_rready   = 1'b0;
    o_m0_rvalid  = 1'b0;
    o_m1_rvalid  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        o_m0_arready = grant_s[0];
        o_m1_arready = grant_s[1];
      end
      ST_ADDR: begin
        // A stray rvalid here is ignored: rready stays low
        o_s_arvalid = 1'b1;
      end
      ST_DATA: begin
        if (owner_r == MST_LSU) begin
          o_m1_rvalid = i_s_rvalid;
          o_s_rready  = i_m1_rready;
        end else begin
          o_m0_rvalid = i_s_rvalid;
          o_s_rready  = i_m0_rready;
        end
      end
      default: begin
        o_s_arvalid = 1'b0;
      end
    endcase
  end

  // FSM, owner/last bookkeeping and address capture
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_r <= ST_IDLE;
      owner_r <= MST_IFU;
      last_r  <= MST_LSU;   // makes the IFU win the first tie
      addr_r  <= 32'h0000_0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          // A non-zero grant means the winner's arvalid and arready are both high
          if (grant_s != 2'b00) begin
            addr_r  <= grant_s[1] ? i_m1_araddr : i_m0_araddr;
            owner_r <= grant_s[1] ? MST_LSU : MST_IFU;
            state_r <= ST_ADDR;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ADDR: begin
          if (i_s_arready) begin
            state_r <= ST_DATA;
          end else begin
            state_r <= ST_ADDR;
          end
        end
        ST_DATA: begin
          if (i_s_rvalid && o_s_rready) begin
            last_r  <= owner_r;
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_DATA;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_24110006_read_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for ysyx_24110006_read_arbiter: a cycle-by-cycle vector table of
// stimulus and hand-computed expected handshake outputs.
// ---------------------------------------------------------------------------
module tb_ysyx_24110006_read_arbiter;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic [31:0] i_m0_araddr, i_m1_araddr;
  logic        i_m0_arvalid, i_m1_arvalid;
  logic        o_m0_arready, o_m1_arready;
  logic [31:0] o_m0_rdata, o_m1_rdata;
  logic [1:0]  o_m0_rresp, o_m1_rresp;
  logic        o_m0_rvalid, o_m1_rvalid;
  logic        i_m0_rready, i_m1_rready;
  logic [31:0] o_s_araddr;
  logic        o_s_arvalid;
  logic        i_s_arready;
  logic [31:0] i_s_rdata;
  logic [1:0]  i_s_rresp;
  logic        i_s_rvalid;
  logic        o_s_rready;

  always #5 i_clock = ~i_clock;

  ysyx_24110006_read_arbiter dut (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_m0_araddr  (i_m0_araddr),
    .i_m0_arvalid (i_m0_arvalid),
    .o_m0_arready (o_m0_arready),
    .o_m0_rdata   (o_m0_rdata),
    .o_m0_rresp   (o_m0_rresp),
    .o_m0_rvalid  (o_m0_rvalid),
    .i_m0_rready  (i_m0_rready),
    .i_m1_araddr  (i_m1_araddr),
    .i_m1_arvalid (i_m1_arvalid),
    .o_m1_arready (o_m1_arready),
    .o_m1_rdata   (o_m1_rdata),
    .o_m1_rresp   (o_m1_rresp),
    .o_m1_rvalid  (o_m1_rvalid),
    .i_m1_rready  (i_m1_rready),
    .o_s_araddr   (o_s_araddr),
    .o_s_arvalid  (o_s_arvalid),
    .i_s_arready  (i_s_arready),
    .i_s_rdata    (i_s_rdata),
    .i_s_rresp    (i_s_rresp),
    .i_s_rvalid   (i_s_rvalid),
    .o_s_rready   (o_s_rready)
  );

  // Expected flag vector: {m0_arready, m1_arready, s_arvalid, s_rready, m0_rvalid, m1_rvalid}
  localparam logic [5:0] E_NONE = 6'b000000;
  localparam logic [5:0] E_M0AR = 6'b100000;
  localparam logic [5:0] E_M1AR = 6'b010000;
  localparam logic [5:0] E_SAV  = 6'b001000;
  localparam logic [5:0] E_SRR  = 6'b000100;
  localparam logic [5:0] E_M0RV = 6'b000010;
  localparam logic [5:0] E_M1RV = 6'b000001;

  typedef struct {
    string       name;
    logic        rst;
    logic        m0v;
    logic [31:0] m0a;
    logic        m1v;
    logic [31:0] m1a;
    logic        m0rr;
    logic        m1rr;
    logic        sar;
    logic        srv;
    logic [31:0] sd;
    logic [1:0]  sr;
    logic [5:0]  e;
    logic [31:0] ea;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic add(input string name, input logic rst,
                     input logic m0v, input logic [31:0] m0a,
                     input logic m1v, input logic [31:0] m1a,
                     input logic m0rr, input logic m1rr,
                     input logic sar, input logic srv,
                     input logic [31:0] sd, input logic [1:0] sr,
                     input logic [5:0] e, input logic [31:0] ea);
    vec_t v;
    v.name = name; v.rst = rst;
    v.m0v = m0v; v.m0a = m0a; v.m1v = m1v; v.m1a = m1a;
    v.m0rr = m0rr; v.m1rr = m1rr; v.sar = sar; v.srv = srv;
    v.sd = sd; v.sr = sr; v.e = e; v.ea = ea;
    vecs.push_back(v);
  endtask

  task automatic check_vec(input int idx, input vec_t v);
    logic [5:0] act;
    act = {o_m0_arready, o_m1_arready, o_s_arvalid, o_s_rready, o_m0_rvalid, o_m1_rvalid};
    n_chk++;
    if (act === v.e) n_pass++;
    else $display("FAIL %s[%0d] flags: got %b, expected %b", v.name, idx, act, v.e);
    if (v.e[3]) begin
      n_chk++;
      if (o_s_araddr === v.ea) n_pass++;
      else $display("FAIL %s[%0d] s_araddr: got %h, expected %h", v.name, idx, o_s_araddr, v.ea);
    end
    n_chk++;
    if (o_m0_rdata === v.sd && o_m1_rdata === v.sd && o_m0_rresp === v.sr && o_m1_rresp === v.sr)
      n_pass++;
    else
      $display("FAIL %s[%0d] rdata/rresp: got %h/%b %h/%b, expected %h/%b", v.name, idx,
               o_m0_rdata, o_m0_rresp, o_m1_rdata, o_m1_rresp, v.sd, v.sr);
  endtask

  initial begin
    logic [31:0] wa;
    logic        w;

    // --- reset state, then single IFU read (rvalid at cycle 2) ---
    add("reset_state", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, E_NONE, 32'h0);
    add("ifu_c0", 1'b0, 1'b1, 32'h8000_0000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, E_M0AR, 32'h0);
    add("ifu_c1", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 2'b00, E_SAV, 32'h8000_0000);
    add("ifu_c2", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0013, 2'b00, E_SRR | E_M0RV, 32'h0);
    add("ifu_c3", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, E_NONE, 32'h0);

    // --- simultaneous requests out of reset: IFU first, LSU waits ---
    add("tie_rst", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, E_NONE, 32'h0);
    add("tie_c0", 1'b0, 1'b1, 32'h8000_0004, 1'b1, 32'h0200_BFF8, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, E_M0AR, 32'h0);
    add("tie_c1", 1'b0, 1'b0, 32'h0, 1'b1, 32'h0200_BFF8, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 2'b00, E_SAV, 32'h8000_0004);
    add("tie_c2", 1'b0, 1'b0, 32'h0, 1'b1, 32'h0200_BFF8, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1111_0000, 2'b00, E_SRR | E_M0RV, 32'h0);
    add("tie_c3", 1'b0, 1'b0, 32'h0, 1'b1, 32'h0200_BFF8, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, E_M1AR, 32'h0);
    add("tie_c4", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 2'b00, E_SAV, 32'h0200_BFF8);
    add("tie_c5", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h2222_0000, 2'b01, E_SRR | E_M1RV, 32'h0);
    add("tie_c6", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, E_NONE, 32'h0);

    // --- continuous contention: grants alternate 0,1,0,1,0,1 ---
    for (int k = 0; k < 6; k++) begin
      w  = (k % 2 == 1);
      wa = w ? (32'h0300_0000 + 32'(k)) : (32'h8000_0100 + 32'(k));
      add("rr_idle", 1'b0, 1'b1, 32'h8000_0100 + 32'(k), 1'b1, 32'h0300_0000 + 32'(k),
          1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, w ? E_M1AR : E_M0AR, 32'h0);
      add("rr_addr", 1'b0, 1'b1, 32'h8000_0100 + 32'(k), 1'b1, 32'h0300_0000 + 32'(k),
          1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 2'b00, E_SAV, wa);
      add("rr_data", 1'b0, 1'b1, 32'h8000_0100 + 32'(k), 1'b1, 32'h0300_0000 + 32'(k),
          1'b1, 1'b1, 1'b0, 1'b1, 32'hA000_0000 + 32'(k), 2'b00, E_SRR | (w ? E_M1RV : E_M0RV), 32'h0);
    end

    // --- LSU read of CLINT hi word, master rready low for 4 cycles ---
    add("lsu_c0", 1'b0, 1'b0, 32'h0, 1'b1, 32'h0200_BFFC, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, E_M1AR, 32'h0);
    add("lsu_c1", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 2'b00, E_SAV, 32'h0200_BFFC);
    for (int k = 0; k < 4; k++)
      add("lsu_stall", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1234_5678, 2'b00, E_M1RV, 32'h0);
    add("lsu_done", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1234_5678, 2'b00, E_SRR | E_M1RV, 32'h0);
    add("lsu_after", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h5555_5555, 2'b00, E_NONE, 32'h0);

    // --- downstream arready low for 5 cycles (one stray rvalid included) ---
    add("ar_c0", 1'b0, 1'b1, 32'h8000_0200, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, E_M0AR, 32'h0);
    for (int k = 0; k < 5; k++)
      add("ar_stall", 1'b0, 1'b1, 32'h8000_0300, 1'b1, 32'h0300_0100, 1'b1, 1'b1, 1'b0, (k == 2),
          32'h0, 2'b00, E_SAV, 32'h8000_0200);
    add("ar_go", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 2'b00, E_SAV, 32'h8000_0200);
    add("ar_data", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0BAD_F00D, 2'b10, E_SRR | E_M0RV, 32'h0);
    add("ar_idle", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, E_NONE, 32'h0);

    // --- reset while in DATA, then a fresh IFU read returning DECERR ---
    add("rd_c0", 1'b0, 1'b1, 32'h8000_0300, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, E_M0AR, 32'h0);
    add("rd_c1", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 2'b00, E_SAV, 32'h8000_0300);
    add("rd_wait", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, E_SRR, 32'h0);
    add("rd_rst", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, E_SRR, 32'h0);
    add("rd_post", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h7777_7777, 2'b00, E_NONE, 32'h0);
    add("rd_new0", 1'b0, 1'b1, 32'h8000_0400, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, E_M0AR, 32'h0);
    add("rd_new1", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 2'b00, E_SAV, 32'h8000_0400);
    add("rd_new2", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 2'b11, E_SRR | E_M0RV, 32'h0);
    add("rd_new3", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, E_NONE, 32'h0);

    // Initial reset with all inputs quiet
    i_reset = 1'b1;
    i_m0_araddr = 32'h0; i_m0_arvalid = 1'b0; i_m0_rready = 1'b0;
    i_m1_araddr = 32'h0; i_m1_arvalid = 1'b0; i_m1_rready = 1'b0;
    i_s_arready = 1'b0; i_s_rdata = 32'h0; i_s_rresp = 2'b00; i_s_rvalid = 1'b0;
    repeat (2) @(posedge i_clock);

    // Drive each vector just after a rising edge, check mid-cycle
    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge i_clock);
      #1;
      i_reset      = vecs[i].rst;
      i_m0_arvalid = vecs[i].m0v;
      i_m0_araddr  = vecs[i].m0a;
      i_m1_arvalid = vecs[i].m1v;
      i_m1_araddr  = vecs[i].m1a;
      i_m0_rready  = vecs[i].m0rr;
      i_m1_rready  = vecs[i].m1rr;
      i_s_arready  = vecs[i].sar;
      i_s_rvalid   = vecs[i].srv;
      i_s_rdata    = vecs[i].sd;
      i_s_rresp    = vecs[i].sr;
      #3;
      check_vec(i, vecs[i]);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
